param_force_distributor: RTL and testbench
==========================================

PARAM_FORCE_DISTRIBUTOR -- requirements
Module: param_force_distributor

Interface
REQ-001 SHALL have parameter NF, default NUM_FILTER, meaning filters/reference lanes per phase.
REQ-002 SHALL have parameter NPH, default 2, meaning phases; slot count NS = NF*NPH.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, meaning neighbour-force FIFO entries (power of 2, >=2).
REQ-004 SHALL have parameter WAIT_CYCLES, default 5, meaning quiet cycles required before reference writeback.
REQ-005 SHALL have one clock; reset is synchronous and active-high; ports are clk and rst.
REQ-006 clk  in  1  clock; rst  in  1  synchronous active-high reset.
REQ-007 start_wb  in  1  request reference writeback; phase  in  $clog2(NPH) (min 1)  phase of ref inputs.
REQ-008 ref_force  in  data_tuple_t[NF]; ref_id  in  full_id_t[NF]; ref_force_valid  in  NF  per-lane capture strobe.
REQ-009 force_in  in  data_tuple_t; nb_id  in  full_id_t; force_valid  in  1  neighbour force strobe.
REQ-010 ready  in  1  bus accepts; wb_out  out  force_wb_t {id, force}; wb_valid  out  1.
REQ-011 all_ref_wb_issued  out  1  one-cycle done pulse; nb_full  out  1  FIFO full; err  out  2  sticky {ref_drop, nb_overflow}.

Function
REQ-012 Transfer SHALL occur only when wb_valid & ready; while wb_valid & ~ready, wb_out and wb_valid SHALL hold stable.
REQ-013 Neighbour path: force_valid SHALL push {nb_id, force_in}; with FIFO empty and output stage free/consumed, entry SHALL appear on wb_out the next cycle (bypass).
REQ-014 Output stage SHALL reload from FIFO head on the cycle it is consumed or empty; FIFO order preserved.
REQ-015 Push when full and no same-cycle pop SHALL drop the entry and set err[0]; push+pop when full SHALL be accepted.
REQ-016 nb_full SHALL be high iff FIFO count == FIFO_DEPTH.
REQ-017 States SHALL be ACTIVE, WAIT, WB_REF; reset state ACTIVE.
REQ-018 ACTIVE/WAIT: for each lane i with ref_force_valid[i], slot phase*NF+i SHALL capture {ref_id[i], ref_force[i]} and set slot valid; re-write of a valid slot overwrites (last wins).
REQ-019 phase >= NPH SHALL be ignored for capture and set err[1].
REQ-020 ACTIVE: start_wb SHALL move to WAIT, clear quiet counter; start_wb ignored in WAIT/WB_REF.
REQ-021 WAIT: quiet counter SHALL reset on force_valid, else increment; exit to WB_REF when counter == WAIT_CYCLES, FIFO empty and output stage empty.
REQ-022 WB_REF: scan pointer 0..NS-1, one slot per cycle; invalid slots skipped without bus cycle; valid slot presented and held until ready, then slot valid cleared.
REQ-023 WB_REF: ref_force_valid SHALL be ignored and set err[1]; force_valid SHALL still push to FIFO; FIFO SHALL not drain during WB_REF.
REQ-024 After slot NS-1 completes (transfer or skip), all_ref_wb_issued SHALL pulse one cycle and state SHALL return to ACTIVE; zero valid slots yields the pulse NS+1 cycles after entry with no wb_valid.
REQ-025 err bits SHALL clear only on rst.

Reset
REQ-026 rst SHALL clear wb_out, wb_valid, all_ref_wb_issued, err, nb_full, all slot data/valids, FIFO pointers/count, counters; state ACTIVE.
REQ-027 rst mid-WB_REF or with FIFO occupied SHALL discard all pending data; first post-reset cycle wb_valid = 0.

Structure
REQ-028 data_tuple_t, full_id_t, force_wb_t, NUM_FILTER SHALL come from md_pkg; no new package types.
REQ-029 Neighbour FIFO SHALL be sub-module force_wb_fifo (param width/depth, push, pop, full, empty, count).

Verification
REQ-030 NF=7,NPH=2: capture lanes 0..6 phase 0, lanes 0..6 phase 1, start_wb -> 14 ordered wb transfers slot 0..13, then one all_ref_wb_issued pulse.
REQ-031 Only slots 3 and 10 valid, ready=1 -> exactly 2 wb_valid cycles, ids of slots 3,10, pulse after scan.
REQ-032 ready=0 for 4 cycles while slot 0 presented -> wb_out unchanged 4 cycles, transfer on 5th.
REQ-033 ready=0, 10 consecutive force_valid, FIFO_DEPTH=8 -> 1 in output stage, 8 queued, 10th dropped, err[0]=1, nb_full=1; drain order matches input.
REQ-034 force_valid every 3rd cycle after start_wb -> remain in WAIT; stop -> WB_REF entered after 5 quiet cycles and FIFO empty.
REQ-035 rst asserted at scan pointer 6 -> next cycle wb_valid=0, state ACTIVE; new start_wb with no captures -> pulse, no wb_valid.

Source files
------------

// File: rtl/md_pkg.sv
// Shared molecular-dynamics datapath types: force tuples, particle ids and
// the writeback record carried on the force bus.
package md_pkg;

  localparam int NUM_FILTER = 7;
  localparam int DATA_W     = 16;
  localparam int ID_W       = 16;

  typedef struct packed {
    logic signed [DATA_W-1:0] x;
    logic signed [DATA_W-1:0] y;
    logic signed [DATA_W-1:0] z;
  } data_tuple_t;

  typedef logic [ID_W-1:0] full_id_t;

  typedef struct packed {
    full_id_t    id;
    data_tuple_t force_val;
  } force_wb_t;

endpackage

// File: rtl/force_wb_fifo.sv
// Neighbour-force queue; a push on a full FIFO is accepted only when a pop
// frees the head slot in the same cycle.
module force_wb_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push, do_pop;

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rd_ptr_q];
  assign count   = cnt_q;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/param_force_distributor.sv
// Merges neighbour forces and per-phase reference forces onto one writeback bus;
// reference slots are flushed in slot order once the neighbour path has gone quiet.
module param_force_distributor
  import md_pkg::*;
#(
  parameter int NF          = NUM_FILTER,
  parameter int NPH         = 2,
  parameter int FIFO_DEPTH  = 8,
  parameter int WAIT_CYCLES = 5
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start_wb,
  input  logic [((NPH > 1) ? $clog2(NPH) : 1)-1:0] phase,
  input  data_tuple_t                          ref_force [NF],
  input  full_id_t                             ref_id [NF],
  input  logic [NF-1:0]                        ref_force_valid,
  input  data_tuple_t                          force_in,
  input  full_id_t                             nb_id,
  input  logic                                 force_valid,
  input  logic                                 ready,
  output force_wb_t                            wb_out,
  output logic                                 wb_valid,
  output logic                                 all_ref_wb_issued,
  output logic                                 nb_full,
  output logic [1:0]                           err
);

  localparam int NS     = NF * NPH;
  localparam int SLOT_W = (NS > 1) ? $clog2(NS) : 1;
  localparam int WCNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {ACTIVE, WAIT, WB_REF} state_e;

  state_e             state_q, state_d;
  force_wb_t          slot_q [NS];
  force_wb_t          slot_d [NS];
  logic [NS-1:0]      slot_vld_q, slot_vld_d;
  logic [SLOT_W-1:0]  ptr_q, ptr_d;
  logic [SLOT_W-1:0]  out_slot_q, out_slot_d;
  logic               scan_done_q, scan_done_d;
  logic [WCNT_W-1:0]  quiet_q, quiet_d;
  force_wb_t          out_q, out_d;
  logic               out_vld_q, out_vld_d;
  logic               done_q, done_d;
  logic [1:0]         err_q, err_d;

  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  force_wb_t          fifo_dout, nb_entry;
  logic [CNT_W-1:0]   fifo_count;
  logic               stage_free;

  assign nb_entry   = '{id: nb_id, force_val: force_in};
  assign stage_free = ~out_vld_q | ready;

  force_wb_fifo #(
    .WIDTH ($bits(force_wb_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (nb_entry),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    slot_vld_d  = slot_vld_q;
    ptr_d       = ptr_q;
    out_slot_d  = out_slot_q;
    scan_done_d = scan_done_q;
    quiet_d     = quiet_q;
    out_d       = out_q;
    out_vld_d   = out_vld_q;
    done_d      = 1'b0;
    err_d       = err_q;
    fifo_push   = 1'b0;
    fifo_pop    = 1'b0;

    if (state_q != WB_REF) begin
      for (int p = 0; p < NPH; p++) begin
        for (int i = 0; i < NF; i++) begin
          if (int'(phase) == p && ref_force_valid[i]) begin
            slot_d[p*NF + i]     = '{id: ref_id[i], force_val: ref_force[i]};
            slot_vld_d[p*NF + i] = 1'b1;
          end
        end
      end
      if (int'(phase) >= NPH && |ref_force_valid) err_d[1] = 1'b1;

      // Neighbour path: the FIFO head has priority; bypass only when the queue is empty.
      if (stage_free) begin
        if (!fifo_empty) begin
          out_d     = fifo_dout;
          out_vld_d = 1'b1;
          fifo_pop  = 1'b1;
          fifo_push = force_valid;
        end else if (force_valid) begin
          out_d     = nb_entry;
          out_vld_d = 1'b1;
        end else begin
          out_vld_d = 1'b0;
        end
      end else begin
        fifo_push = force_valid;
      end
    end else begin
      fifo_push = force_valid;
      if (|ref_force_valid) err_d[1] = 1'b1;
      if (out_vld_q && ready) slot_vld_d[out_slot_q] = 1'b0;

      // Scan advances only while the bus can take a new word; empty slots cost one cycle.
      if (stage_free) begin
        out_vld_d = 1'b0;
        if (!scan_done_q) begin
          if (slot_vld_q[ptr_q]) begin
            out_d      = slot_q[ptr_q];
            out_vld_d  = 1'b1;
            out_slot_d = ptr_q;
          end
          if (ptr_q == SLOT_W'(NS - 1)) scan_done_d = 1'b1;
          else                          ptr_d       = ptr_q + 1'b1;
        end
        if (scan_done_d && !out_vld_d) begin
          done_d      = 1'b1;
          state_d     = ACTIVE;
          ptr_d       = '0;
          scan_done_d = 1'b0;
        end
      end
    end

    if (fifo_push && fifo_full && !fifo_pop) err_d[0] = 1'b1;

    case (state_q)
      ACTIVE: begin
        if (start_wb) begin
          state_d = WAIT;
          quiet_d = '0;
        end
      end
      WAIT: begin
        if (force_valid) begin
          quiet_d = '0;
        end else if (quiet_q == WCNT_W'(WAIT_CYCLES) && fifo_empty && !out_vld_q) begin
          state_d     = WB_REF;
          ptr_d       = '0;
          scan_done_d = 1'b0;
        end else if (quiet_q != WCNT_W'(WAIT_CYCLES)) begin
          quiet_d = quiet_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACTIVE;
      slot_q      <= '{default: '0};
      slot_vld_q  <= '0;
      ptr_q       <= '0;
      out_slot_q  <= '0;
      scan_done_q <= 1'b0;
      quiet_q     <= '0;
      out_q       <= '0;
      out_vld_q   <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      slot_vld_q  <= slot_vld_d;
      ptr_q       <= ptr_d;
      out_slot_q  <= out_slot_d;
      scan_done_q <= scan_done_d;
      quiet_q     <= quiet_d;
      out_q       <= out_d;
      out_vld_q   <= out_vld_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign wb_out            = out_q;
  assign wb_valid          = out_vld_q;
  assign all_ref_wb_issued = done_q;
  assign err               = err_q;
  assign nb_full           = (fifo_count == CNT_W'(FIFO_DEPTH));

endmodule

// File: tb/tb_param_force_distributor.sv
// Directed bench for param_force_distributor at NF=7, NPH=2, FIFO_DEPTH=8, WAIT_CYCLES=5.
module tb_param_force_distributor;
  import md_pkg::*;

  localparam int NF = 7;
  localparam int NS = 14;

  logic           clk = 1'b0;
  logic           rst, start_wb, force_valid, ready;
  logic [0:0]     phase;
  data_tuple_t    ref_force [NF];
  full_id_t       ref_id [NF];
  logic [NF-1:0]  ref_force_valid;
  data_tuple_t    force_in;
  full_id_t       nb_id;
  force_wb_t      wb_out;
  logic           wb_valid, all_ref_wb_issued, nb_full;
  logic [1:0]     err;

  int             errors = 0;
  int             checks = 0;
  force_wb_t      got [NS];

  param_force_distributor dut (
    .clk               (clk),
    .rst               (rst),
    .start_wb          (start_wb),
    .phase             (phase),
    .ref_force         (ref_force),
    .ref_id            (ref_id),
    .ref_force_valid   (ref_force_valid),
    .force_in          (force_in),
    .nb_id             (nb_id),
    .force_valid       (force_valid),
    .ready             (ready),
    .wb_out            (wb_out),
    .wb_valid          (wb_valid),
    .all_ref_wb_issued (all_ref_wb_issued),
    .nb_full           (nb_full),
    .err               (err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic force_wb_t mk_ref(input int s);
    force_wb_t r;
    r.id          = full_id_t'(32'h0100 + s);
    r.force_val.x = DATA_W'(s * 3 - 20);
    r.force_val.y = DATA_W'(-7 * s);
    r.force_val.z = DATA_W'(s * 16);
    return r;
  endfunction

  function automatic force_wb_t mk_nb(input int n);
    force_wb_t r;
    r.id          = full_id_t'(32'hA000 + n);
    r.force_val.x = DATA_W'(n * 11);
    r.force_val.y = DATA_W'(-n);
    r.force_val.z = DATA_W'(1000 - n);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cap(input logic ph, input logic [NF-1:0] mask);
    force_wb_t t;
    phase = ph;
    for (int i = 0; i < NF; i++) begin
      t            = mk_ref(int'(ph) * NF + i);
      ref_id[i]    = t.id;
      ref_force[i] = t.force_val;
    end
    ref_force_valid = mask;
    tick();
    ref_force_valid = '0;
  endtask

  task automatic start();
    start_wb = 1'b1;
    tick();
    start_wb = 1'b0;
  endtask

  // Samples k=1..max after the start edge; records transfers and pulses.
  task automatic run_scan(input int max_k, input int inj_k, output int nv,
                          output int first_k, output int pulse_k, output int npulse);
    nv = 0; first_k = -1; pulse_k = -1; npulse = 0;
    for (int k = 1; k <= max_k; k++) begin
      ref_force_valid = (k == inj_k) ? '1 : '0;
      tick();
      if (wb_valid) begin
        if (nv == 0) first_k = k;
        if (nv < NS) got[nv] = wb_out;
        nv++;
      end
      if (all_ref_wb_issued) begin
        npulse++;
        if (pulse_k < 0) pulse_k = k;
      end
    end
    ref_force_valid = '0;
  endtask

  initial begin
    int nv, fk, pk, np, lat;
    logic seen, bad;
    force_wb_t t;

    rst = 1'b1; start_wb = 1'b0; force_valid = 1'b0; ready = 1'b0; phase = '0;
    ref_force_valid = '0; force_in = '0; nb_id = '0;
    for (int i = 0; i < NF; i++) begin
      ref_force[i] = '0;
      ref_id[i]    = '0;
    end
    tick(); tick();
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_pulse", 64'(all_ref_wb_issued), 64'd0);
    chk("rst_nb_full", 64'(nb_full), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_wb_out", 64'(wb_out), 64'd0);
    rst = 1'b0;
    tick();

    // Full 14-slot flush in slot order
    ready = 1'b1;
    cap(1'b0, 7'h7f);
    cap(1'b1, 7'h7f);
    start();
    run_scan(40, -1, nv, fk, pk, np);
    chk("full_count", 64'(nv), 64'd14);
    chk("full_first_k", 64'(fk), 64'd7);
    chk("full_pulse_k", 64'(pk), 64'd21);
    chk("full_npulse", 64'(np), 64'd1);
    for (int s = 0; s < NS; s++) chk($sformatf("full_slot%0d", s), got[s], mk_ref(s));
    chk("full_err", 64'(err), 64'd0);

    // Sparse: only slots 3 and 10
    cap(1'b0, 7'b0001000);
    cap(1'b1, 7'b0001000);
    start();
    run_scan(30, -1, nv, fk, pk, np);
    chk("sparse_count", 64'(nv), 64'd2);
    chk("sparse_slot3", got[0], mk_ref(3));
    chk("sparse_slot10", got[1], mk_ref(10));
    chk("sparse_first_k", 64'(fk), 64'd10);
    chk("sparse_pulse_k", 64'(pk), 64'd20);
    chk("sparse_npulse", 64'(np), 64'd1);

    // Back-pressure on slot 0
    ready = 1'b0;
    cap(1'b0, 7'h01);
    start();
    seen = 1'b0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      tick();
      if (wb_valid) seen = 1'b1;
    end
    chk("stall_presented", 64'(seen), 64'd1);
    chk("stall_data_c1", wb_out, mk_ref(0));
    for (int c = 2; c <= 4; c++) begin
      tick();
      chk($sformatf("stall_vld_c%0d", c), 64'(wb_valid), 64'd1);
      chk($sformatf("stall_data_c%0d", c), wb_out, mk_ref(0));
    end
    ready = 1'b1;
    tick();
    chk("stall_taken", 64'(wb_valid), 64'd0);
    run_scan(20, -1, nv, fk, pk, np);
    chk("stall_extra_vld", 64'(nv), 64'd0);
    chk("stall_npulse", 64'(np), 64'd1);

    // Neighbour overflow: 1 staged, 8 queued, 10th dropped
    ready = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      t           = mk_nb(n);
      nb_id       = t.id;
      force_in    = t.force_val;
      force_valid = 1'b1;
      tick();
    end
    force_valid = 1'b0;
    chk("ovf_nb_full", 64'(nb_full), 64'd1);
    chk("ovf_err", 64'(err), 64'd1);
    ready = 1'b1;
    for (int n = 1; n <= 9; n++) begin
      chk($sformatf("ovf_vld%0d", n), 64'(wb_valid), 64'd1);
      chk($sformatf("ovf_data%0d", n), wb_out, mk_nb(n));
      tick();
    end
    chk("ovf_drained", 64'(wb_valid), 64'd0);
    chk("ovf_nb_full_clr", 64'(nb_full), 64'd0);

    // Neighbour activity every 3rd cycle holds the block in WAIT
    cap(1'b0, 7'h01);
    start();
    bad = 1'b0;
    for (int c = 0; c < 30; c++) begin
      t           = mk_nb(100 + c);
      nb_id       = t.id;
      force_in    = t.force_val;
      force_valid = (c % 3 == 0);
      tick();
      if (all_ref_wb_issued || (wb_valid && wb_out.id == mk_ref(0).id)) bad = 1'b1;
    end
    force_valid = 1'b0;
    chk("quiet_no_ref", 64'(bad), 64'd0);
    lat = -1;
    for (int k = 3; k <= 20 && lat < 0; k++) begin
      tick();
      if (wb_valid && wb_out.id == mk_ref(0).id) lat = k;
    end
    chk("quiet_latency", 64'(lat), 64'd7);
    run_scan(20, -1, nv, fk, pk, np);
    chk("quiet_npulse", 64'(np), 64'd1);

    // Reset in the middle of a flush
    cap(1'b0, 7'h7f);
    cap(1'b1, 7'h7f);
    start();
    for (int k = 1; k <= 12; k++) tick();
    chk("mid_slot5", wb_out, mk_ref(5));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_vld", 64'(wb_valid), 64'd0);
    chk("mid_rst_out", 64'(wb_out), 64'd0);
    chk("mid_rst_err", 64'(err), 64'd0);
    chk("mid_rst_pulse", 64'(all_ref_wb_issued), 64'd0);
    start();
    chk("post_rst_vld", 64'(wb_valid), 64'd0);
    run_scan(30, 11, nv, fk, pk, np);
    chk("post_rst_count", 64'(nv), 64'd0);
    chk("post_rst_pulse_k", 64'(pk), 64'd20);
    chk("post_rst_npulse", 64'(np), 64'd1);
    chk("post_rst_ref_drop", 64'(err), 64'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
